// File: rtl/vga_fsm.sv
// vga_fsm: free-running VGA raster timing generator.
// A pixel-rate tick is derived from the system clock. Horizontal and vertical
// counters advance on that tick. All video outputs are registered decodes of
// the current counter values.
module vga_fsm #(
    parameter int PIX_DIV  = 2,
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic       clk,
    input  logic       rst,
    output logic [8:0] row,
    output logic [9:0] col,
    output logic       Hsync,
    output logic       Vsync,
    output logic       en_r,
    output logic       hBlank,
    output logic       vBlank
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int HW      = $clog2(H_TOTAL);
    localparam int VW      = $clog2(V_TOTAL);
    localparam int PW      = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;

    localparam logic [PW-1:0] P_LAST   = PW'(PIX_DIV - 1);
    localparam logic [HW-1:0] H_LAST   = HW'(H_TOTAL - 1);
    localparam logic [VW-1:0] V_LAST   = VW'(V_TOTAL - 1);
    localparam logic [HW-1:0] H_VIS    = HW'(H_ACTIVE);
    localparam logic [HW-1:0] HS_START = HW'(H_ACTIVE + H_FP);
    localparam logic [HW-1:0] HS_END   = HW'(H_ACTIVE + H_FP + H_SYNC);
    localparam logic [VW-1:0] V_VIS    = VW'(V_ACTIVE);
    localparam logic [VW-1:0] VS_START = VW'(V_ACTIVE + V_FP);
    localparam logic [VW-1:0] VS_END   = VW'(V_ACTIVE + V_FP + V_SYNC);

    logic [PW-1:0] pdiv;
    logic [HW-1:0] hcount;
    logic [VW-1:0] vcount;
    logic          tick;

    logic          h_blank_d;
    logic          v_blank_d;
    logic          hsync_d;
    logic          vsync_d;
    logic [9:0]    col_d;
    logic [8:0]    row_d;

    assign tick = (pdiv == P_LAST);

    // Pixel divider and raster counters; vcount steps only when hcount wraps.
    always_ff @(posedge clk) begin
        if (rst) begin
            pdiv   <= '0;
            hcount <= '0;
            vcount <= '0;
        end else begin
            pdiv <= tick ? '0 : pdiv + PW'(1);
            if (tick) begin
                if (hcount == H_LAST) begin
                    hcount <= '0;
                    vcount <= (vcount == V_LAST) ? '0 : vcount + VW'(1);
                end else begin
                    hcount <= hcount + HW'(1);
                end
            end
        end
    end

    // Combinational decode of the current counter position.
    always_comb begin
        h_blank_d = 1'b0;
        v_blank_d = 1'b0;
        hsync_d   = 1'b1;
        vsync_d   = 1'b1;
        col_d     = '0;
        row_d     = '0;
        h_blank_d = (hcount >= H_VIS);
        v_blank_d = (vcount >= V_VIS);
        hsync_d   = !((hcount >= HS_START) && (hcount < HS_END));
        vsync_d   = !((vcount >= VS_START) && (vcount < VS_END));
        if (!h_blank_d) col_d = 10'(hcount);
        if (!v_blank_d) row_d = 9'(vcount);
    end

    // Output register: one clock behind the counters, reset to idle levels.
    always_ff @(posedge clk) begin
        if (rst) begin
            row    <= '0;
            col    <= '0;
            Hsync  <= 1'b1;
            Vsync  <= 1'b1;
            en_r   <= 1'b0;
            hBlank <= 1'b0;
            vBlank <= 1'b0;
        end else begin
            row    <= row_d;
            col    <= col_d;
            Hsync  <= hsync_d;
            Vsync  <= vsync_d;
            en_r   <= !h_blank_d && !v_blank_d;
            hBlank <= h_blank_d;
            vBlank <= v_blank_d;
        end
    end

endmodule

// File: tb/tb_vga_fsm.sv
// Bench for vga_fsm: three instances (standard timing at PIX_DIV 2 and 1, and a
// reduced raster at PIX_DIV 3 for whole-frame behaviour), a cycle-count based
// reference model, a vector table, and line/frame measurement sequences.
module tb_vga_fsm;

    typedef struct packed {
        logic [9:0] row;
        logic [9:0] col;
        logic       hs;
        logic       vs;
        logic       en;
        logic       hb;
        logic       vb;
    } out_t;

    typedef struct {
        int   k;
        out_t e;
    } vec_t;

    localparam int S_PD = 3, S_HA = 8, S_HF = 2, S_HS = 3, S_HB = 2;
    localparam int S_VA = 6, S_VF = 1, S_VS = 2, S_VB = 2;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
    logic [8:0] row0, row1, row2;
    logic [9:0] col0, col1, col2;
    logic hs0, hs1, hs2, vs0, vs1, vs2, en0, en1, en2;
    logic hb0, hb1, hb2, vb0, vb1, vb2;

    vga_fsm #(.PIX_DIV(2)) u0 (
        .clk(clk), .rst(rst0), .row(row0), .col(col0), .Hsync(hs0), .Vsync(vs0),
        .en_r(en0), .hBlank(hb0), .vBlank(vb0));

    vga_fsm #(.PIX_DIV(1)) u1 (
        .clk(clk), .rst(rst1), .row(row1), .col(col1), .Hsync(hs1), .Vsync(vs1),
        .en_r(en1), .hBlank(hb1), .vBlank(vb1));

    vga_fsm #(.PIX_DIV(S_PD), .H_ACTIVE(S_HA), .H_FP(S_HF), .H_SYNC(S_HS), .H_BP(S_HB),
              .V_ACTIVE(S_VA), .V_FP(S_VF), .V_SYNC(S_VS), .V_BP(S_VB)) u2 (
        .clk(clk), .rst(rst2), .row(row2), .col(col2), .Hsync(hs2), .Vsync(vs2),
        .en_r(en2), .hBlank(hb2), .vBlank(vb2));

    int n_chk  = 0;
    int n_fail = 0;
    bit done1  = 1'b0;
    bit done2  = 1'b0;

    // k = clock edges since the last edge that saw reset (0 means in reset)
    int k0 = 0, k1 = 0, k2 = 0;
    bit live0 = 1'b0, live1 = 1'b0, live2 = 1'b0;

    function automatic out_t reset_out();
        out_t o;
        o = '0;
        o.hs = 1'b1;
        o.vs = 1'b1;
        return o;
    endfunction

    // Reference: pixel index from elapsed clocks, position from division.
    function automatic out_t model(int k, int pd, int ha, int hf, int hsw, int hbp,
                                   int va, int vf, int vsw, int vbp);
        out_t o;
        int n, h, v, ht, vt;
        if (k == 0) return reset_out();
        ht = ha + hf + hsw + hbp;
        vt = va + vf + vsw + vbp;
        n = (k - 1) / pd;
        h = n % ht;
        v = (n / ht) % vt;
        o.hb  = (h >= ha);
        o.vb  = (v >= va);
        o.en  = !o.hb && !o.vb;
        o.hs  = !((h >= ha + hf) && (h < ha + hf + hsw));
        o.vs  = !((v >= va + vf) && (v < va + vf + vsw));
        o.col = o.hb ? 10'd0 : 10'(h);
        o.row = o.vb ? 10'd0 : 10'(v);
        return o;
    endfunction

    function automatic out_t mk(logic [8:0] r, logic [9:0] c, logic hs, logic vs,
                                logic en, logic hb, logic vb);
        out_t o;
        o.row = {1'b0, r};
        o.col = c;
        o.hs = hs; o.vs = vs; o.en = en; o.hb = hb; o.vb = vb;
        return o;
    endfunction

    function automatic vec_t mkv(int k, int r, int c, int hs, int vs, int en, int hb, int vb);
        vec_t x;
        x.k = k;
        x.e.row = 10'(r);
        x.e.col = 10'(c);
        x.e.hs = (hs != 0); x.e.vs = (vs != 0); x.e.en = (en != 0);
        x.e.hb = (hb != 0); x.e.vb = (vb != 0);
        return x;
    endfunction

    task automatic check_out(input string nm, input out_t got, input out_t exp);
        n_chk++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got row=%0d col=%0d hs=%b vs=%b en=%b hb=%b vb=%b want row=%0d col=%0d hs=%b vs=%b en=%b hb=%b vb=%b",
                     nm, $time, got.row, got.col, got.hs, got.vs, got.en, got.hb, got.vb,
                     exp.row, exp.col, exp.hs, exp.vs, exp.en, exp.hb, exp.vb);
        end
    endtask

    task automatic check_int(input string nm, input int got, input int exp);
        n_chk++;
        if (got != exp) begin
            n_fail++;
            $display("FAIL %s t=%0t got %0d want %0d", nm, $time, got, exp);
        end
    endtask

    // Model tick-along: count edges since reset per instance.
    always @(posedge clk) begin
        k0 <= rst0 ? 0 : k0 + 1;
        k1 <= rst1 ? 0 : k1 + 1;
        k2 <= rst2 ? 0 : k2 + 1;
        live0 <= 1'b1; live1 <= 1'b1; live2 <= 1'b1;
    end

    // Every-cycle comparison of each instance against the reference model.
    always @(negedge clk) begin
        if (live0) check_out("model0", mk(row0, col0, hs0, vs0, en0, hb0, vb0),
                             model(k0, 2, 640, 16, 96, 48, 480, 10, 2, 33));
        if (live1) check_out("model1", mk(row1, col1, hs1, vs1, en1, hb1, vb1),
                             model(k1, 1, 640, 16, 96, 48, 480, 10, 2, 33));
        if (live2) check_out("model2", mk(row2, col2, hs2, vs2, en2, hb2, vb2),
                             model(k2, S_PD, S_HA, S_HF, S_HS, S_HB, S_VA, S_VF, S_VS, S_VB));
    end

    task automatic wait_k0(input int target);
        int g;
        g = 0;
        while (k0 < target && g < 10000) begin
            @(negedge clk);
            g++;
        end
        check_int("reach_k0", k0, target);
    endtask

    // Standard timing, PIX_DIV=2: reset, vector table, mid-line reset, one line.
    initial begin
        vec_t vecs[12];
        int ec, hc, first, last_en, g;
        vecs[0]  = mkv(1,    0, 0,   1, 1, 1, 0, 0);
        vecs[1]  = mkv(2,    0, 0,   1, 1, 1, 0, 0);
        vecs[2]  = mkv(3,    0, 1,   1, 1, 1, 0, 0);
        vecs[3]  = mkv(1279, 0, 639, 1, 1, 1, 0, 0);
        vecs[4]  = mkv(1281, 0, 0,   1, 1, 0, 1, 0);
        vecs[5]  = mkv(1312, 0, 0,   1, 1, 0, 1, 0);
        vecs[6]  = mkv(1313, 0, 0,   0, 1, 0, 1, 0);
        vecs[7]  = mkv(1504, 0, 0,   0, 1, 0, 1, 0);
        vecs[8]  = mkv(1505, 0, 0,   1, 1, 0, 1, 0);
        vecs[9]  = mkv(1601, 1, 0,   1, 1, 1, 0, 0);
        vecs[10] = mkv(2881, 1, 0,   1, 1, 0, 1, 0);
        vecs[11] = mkv(3001, 1, 0,   0, 1, 0, 1, 0);

        repeat (3) @(posedge clk);
        @(negedge clk);
        check_out("rst_hold", mk(row0, col0, hs0, vs0, en0, hb0, vb0), reset_out());
        rst0 = 1'b0;

        for (int i = 0; i < 12; i++) begin
            wait_k0(vecs[i].k);
            check_out($sformatf("vec%0d", i), mk(row0, col0, hs0, vs0, en0, hb0, vb0), vecs[i].e);
        end

        // mid-line reset at hcount 700 of line 1
        rst0 = 1'b1;
        @(negedge clk);
        check_out("midline_rst", mk(row0, col0, hs0, vs0, en0, hb0, vb0), reset_out());
        rst0 = 1'b0;
        @(negedge clk);
        check_out("restart_k1", mk(row0, col0, hs0, vs0, en0, hb0, vb0), mkv(1, 0, 0, 1, 1, 1, 0, 0).e);
        @(negedge clk);
        @(negedge clk);
        check_int("restart_col1", int'(col0), 1);

        // one full line from a fresh start
        rst0 = 1'b1;
        @(negedge clk);
        rst0 = 1'b0;
        @(negedge clk);
        ec = 0; hc = 0; first = -1; last_en = 0;
        for (int i = 0; i < 1600; i++) begin
            if (en0) ec++;
            if (!hs0) begin
                hc++;
                if (first < 0) first = i;
            end
            last_en = int'(en0);
            @(negedge clk);
        end
        check_int("line0_en_clk", ec, 1280);
        check_int("line0_hs_low", hc, 192);
        check_int("line0_hs_start", first, 1312);
        check_int("line0_en_end", last_en, 0);
        check_int("line0_next_row", int'(row0), 1);
        check_int("line0_next_en", int'(en0), 1);
        check_int("line0_next_col", int'(col0), 0);

        g = 0;
        while (!(done1 && done2) && g < 20000) begin
            @(negedge clk);
            g++;
        end
        check_int("others_done", int'(done1 && done2), 1);
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

    // Standard timing, PIX_DIV=1: one line.
    initial begin
        int ec, hc, first;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst1 = 1'b0;
        @(negedge clk);
        ec = 0; hc = 0; first = -1;
        for (int i = 0; i < 800; i++) begin
            if (en1) ec++;
            if (!hs1) begin
                hc++;
                if (first < 0) first = i;
            end
            @(negedge clk);
        end
        check_int("line1_en_clk", ec, 640);
        check_int("line1_hs_low", hc, 96);
        check_int("line1_hs_start", first, 656);
        check_int("line1_next_row", int'(row1), 1);
        done1 = 1'b1;
    end

    // Reduced raster, PIX_DIV=3: one frame, mid-frame reset, random resets.
    initial begin
        int vc, first, bc, ec;
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst2 = 1'b0;
        @(negedge clk);
        vc = 0; first = -1; bc = 0; ec = 0;
        for (int i = 0; i < 495; i++) begin
            if (!vs2) begin
                vc++;
                if (first < 0) first = i;
            end
            if (vb2) bc++;
            if (en2) ec++;
            @(negedge clk);
        end
        check_int("frame2_vs_low", vc, 90);
        check_int("frame2_vs_start", first, 315);
        check_int("frame2_vblank", bc, 225);
        check_int("frame2_en_clk", ec, 144);
        check_out("frame2_wrap", mk(row2, col2, hs2, vs2, en2, hb2, vb2), mkv(1, 0, 0, 1, 1, 1, 0, 0).e);

        repeat (200) @(negedge clk);
        rst2 = 1'b1;
        @(negedge clk);
        check_out("midframe_rst", mk(row2, col2, hs2, vs2, en2, hb2, vb2), reset_out());
        rst2 = 1'b0;
        @(negedge clk);
        check_out("midframe_k1", mk(row2, col2, hs2, vs2, en2, hb2, vb2), mkv(1, 0, 0, 1, 1, 1, 0, 0).e);

        for (int i = 0; i < 3000; i++) begin
            @(negedge clk);
            if ($urandom_range(0, 149) == 0) rst2 = 1'b1;
            else if (rst2 && $urandom_range(0, 1) == 0) rst2 = 1'b1;
            else rst2 = 1'b0;
        end
        rst2 = 1'b0;
        repeat (10) @(negedge clk);
        done2 = 1'b1;
    end

endmodule
